// File: rtl/interp_pkg.sv
// Shared definitions for the interpolation datapath: sample-row width,
// routing state encoding and the default burst length for the row demux.
package interp_pkg;

  localparam int SAMPLE_ROW_W  = 165;
  localparam int BURST_LEN_DEF = 8;
  localparam int NUM_BR        = 2;

  typedef enum logic {
    R0 = 1'b0,
    R1 = 1'b1
  } route_e;

endpackage

// File: rtl/out_slot_reg.sv
// One-entry valid/ready output register. The parent raises load only when
// the slot reports free, so a drain and a refill may share a cycle.
module out_slot_reg
  import interp_pkg::*;
#(
  parameter int WIDTH = SAMPLE_ROW_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             rdy,
  output logic [WIDTH-1:0] dout,
  output logic             vld,
  output logic             free
);

  assign free = ~vld | rdy;

  // Data only moves on load, so a drained slot keeps its last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      vld  <= 1'b0;
    end else if (load) begin
      dout <= din;
      vld  <= 1'b1;
    end else if (rdy) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_12_reg.sv
// Registered 1:2 demux for sample rows, explicit (sel) or auto-alternating
// bursts. Define DEMUX_12_BEAT_CNT_EN to add per-branch delivered-beat counters.
module demux_12_reg
  import interp_pkg::*;
#(
  parameter int WIDTH     = SAMPLE_ROW_W,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int CNT_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    sel,
  input  logic                    mode,
  output logic signed [WIDTH-1:0] out0,
  output logic                    out0_valid,
  input  logic                    out0_ready,
  output logic signed [WIDTH-1:0] out1,
  output logic                    out1_valid,
  input  logic                    out1_ready,
`ifdef DEMUX_12_BEAT_CNT_EN
  output logic [15:0]             beats0,
  output logic [15:0]             beats1,
`endif
  output logic                    route
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  logic [NUM_BR-1:0]            slot_rdy, slot_vld, slot_free, slot_load;
  logic [NUM_BR-1:0][WIDTH-1:0] slot_dat;

  route_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q;
  logic             tgt, accept, mode_chg;

  assign slot_rdy = {out1_ready, out0_ready};
  assign tgt      = mode ? state_q : sel;
  assign route    = tgt;
  assign in_ready = slot_free[tgt];
  assign accept   = in_valid & in_ready;
  assign mode_chg = mode ^ mode_q;

  for (genvar b = 0; b < NUM_BR; b++) begin : g_slot
    assign slot_load[b] = accept & (tgt == 1'(b));
    out_slot_reg #(.WIDTH(WIDTH)) u_slot (
      .clk  (clk),
      .rst_n(rst_n),
      .load (slot_load[b]),
      .din  (in),
      .rdy  (slot_rdy[b]),
      .dout (slot_dat[b]),
      .vld  (slot_vld[b]),
      .free (slot_free[b])
    );
  end

  assign out0       = slot_dat[0];
  assign out1       = slot_dat[1];
  assign out0_valid = slot_vld[0];
  assign out1_valid = slot_vld[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= R0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode;
    end
  end

  // A mode change wins over any burst progress made on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (mode_chg) begin
      state_d = R0;
      cnt_d   = '0;
    end else if (mode && accept) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = (state_q == R0) ? R1 : R0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

`ifdef DEMUX_12_BEAT_CNT_EN
  logic [NUM_BR-1:0][15:0] beats_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_q <= '0;
    end else begin
      for (int b = 0; b < NUM_BR; b++) begin
        if (mode_chg)
          beats_q[b] <= '0;
        else if (slot_vld[b] & slot_rdy[b])
          beats_q[b] <= beats_q[b] + 16'd1;
      end
    end
  end

  assign beats0 = beats_q[0];
  assign beats1 = beats_q[1];
`endif

endmodule

// File: tb/tb_demux_12_reg.sv
// Directed self-checking bench for demux_12_reg (default build; beat counter
// checks are included when DEMUX_12_BEAT_CNT_EN is defined).
module tb_demux_12_reg;
  localparam int W = 165;

  logic                clk = 1'b0;
  logic                rst_n;
  logic signed [W-1:0] din;
  logic                in_valid, in_ready, sel, mode;
  logic signed [W-1:0] out0, out1;
  logic                out0_valid, out1_valid, out0_ready, out1_ready, route;
`ifdef DEMUX_12_BEAT_CNT_EN
  logic [15:0]         beats0, beats1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_12_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out0      (out0),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1      (out1),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
`ifdef DEMUX_12_BEAT_CNT_EN
    .beats0    (beats0),
    .beats1    (beats1),
`endif
    .route     (route)
  );

  task automatic idle_drain();
    @(negedge clk);
    in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [W-1:0] exp_a;
    exp_a = 165'h1_2345;
    rst_n = 1'b0; din = '0; in_valid = 1'b0; sel = 1'b0; mode = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({out0_valid, out1_valid, in_ready, route} !== 4'b0010) begin
      errors++; $display("FAIL reset_state got v0=%b v1=%b rdy=%b route=%b want 0 0 1 0",
                         out0_valid, out1_valid, in_ready, route); end
    checks++; if (out0 !== '0 || out1 !== '0) begin
      errors++; $display("FAIL reset_data got out0=%h out1=%h want 0", out0, out1); end
`ifdef DEMUX_12_BEAT_CNT_EN
    checks++; if (beats0 !== 16'd0 || beats1 !== 16'd0) begin
      errors++; $display("FAIL reset_beats got %0d %0d want 0 0", beats0, beats1); end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); din = exp_a; sel = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out0_valid !== 1'b1 || out0 !== exp_a) begin
      errors++; $display("FAIL pre_reset_load got v=%b d=%h want 1 %h", out0_valid, out0, exp_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({out0_valid, out1_valid, in_ready, route} !== 4'b0010 || out0 !== '0) begin
      errors++; $display("FAIL async_reset got v0=%b v1=%b rdy=%b route=%b out0=%h want 0 0 1 0 0",
                         out0_valid, out1_valid, in_ready, route, out0); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_explicit();
    logic signed [W-1:0] m5;
    m5 = -165'sd5;
    @(negedge clk);
    mode = 1'b0; sel = 1'b1; din = m5; in_valid = 1'b1; out0_ready = 1'b0; out1_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (out1 !== m5 || out1_valid !== 1'b1 || out0_valid !== 1'b0) begin
      errors++; $display("FAIL explicit_sel1 got out1=%h v1=%b v0=%b want %h 1 0",
                         out1, out1_valid, out0_valid, m5); end
    @(negedge clk); in_valid = 1'b0; out1_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out1_valid !== 1'b0 || out1 !== m5) begin
      errors++; $display("FAIL drain_hold got v1=%b out1=%h want 0 %h", out1_valid, out1, m5); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b;
    a = 165'hAAAA_0001; b = 165'h5555_0002;
    @(negedge clk);
    out0_ready = 1'b0; out1_ready = 1'b0; sel = 1'b0; din = a; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); din = b;
    #1;
    checks++; if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out0 !== a || out0_valid !== 1'b1 || out1_valid !== 1'b0) begin
      errors++; $display("FAIL bp_hold got out0=%h v0=%b v1=%b want %h 1 0",
                         out0, out0_valid, out1_valid, a); end
    @(negedge clk); sel = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || route !== 1'b1) begin
      errors++; $display("FAIL bp_resteer got rdy=%b route=%b want 1 1", in_ready, route); end
    @(posedge clk); #1;
    checks++; if (out1 !== b || out1_valid !== 1'b1 || out0 !== a || out0_valid !== 1'b1) begin
      errors++; $display("FAIL bp_land got out1=%h v1=%b out0=%h want %h 1 %h", out1, out1_valid, out0, b, a); end
    idle_drain();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    out0_ready = 1'b1; sel = 1'b0; mode = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(negedge clk);
      din = W'(i); in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready beat %0d got %b want 1", i, in_ready); end
      @(posedge clk); #1;
      checks++; if (out0 !== W'(i) || out0_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_data beat %0d got %0d v=%b want %0d 1", i, out0, out0_valid, i); end
    end
    idle_drain();
    checks++; if (out0_valid !== 1'b0 || out0 !== W'(4)) begin
      errors++; $display("FAIL b2b_empty got v=%b d=%0d want 0 4", out0_valid, out0); end
  endtask

  task automatic test_auto();
    logic exp_br;
    @(negedge clk);
    mode = 1'b1; in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
    @(posedge clk);
    // 20 beats: 0-7 -> 0, 8-15 -> 1, 16-19 -> 0
    for (int i = 0; i < 20; i++) begin
      exp_br = ((i / 8) % 2) == 1;
      @(negedge clk); din = W'(i); in_valid = 1'b1; sel = ~exp_br;
      #1;
      checks++; if (route !== exp_br) begin
        errors++; $display("FAIL auto_route beat %0d got %b want %b", i, route, exp_br); end
      @(posedge clk); #1;
      if (exp_br) begin
        checks++; if (out1 !== W'(i) || out1_valid !== 1'b1) begin
          errors++; $display("FAIL auto_out1 beat %0d got %0d v=%b want %0d 1", i, out1, out1_valid, i); end
      end else begin
        checks++; if (out0 !== W'(i) || out0_valid !== 1'b1) begin
          errors++; $display("FAIL auto_out0 beat %0d got %0d v=%b want %0d 1", i, out0, out0_valid, i); end
      end
    end
    // Toggle mode away and back: counter cleared, so 8 full beats to OUT0, 9th to OUT1.
    @(negedge clk); in_valid = 1'b0; mode = 1'b0;
    @(posedge clk);
    @(negedge clk); mode = 1'b1;
    #1;
    checks++; if (route !== 1'b0) begin
      errors++; $display("FAIL auto_mode_clr route got %b want 0", route); end
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      exp_br = (i == 8);
      @(negedge clk); din = W'(100 + i); in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if ((exp_br ? out1 : out0) !== W'(100 + i)) begin
        errors++; $display("FAIL auto_restart beat %0d got out0=%0d out1=%0d want %0d on %b",
                           i, out0, out1, 100 + i, exp_br); end
    end
    // Now in R1; a mode change must return the state to R0.
    @(negedge clk); in_valid = 1'b0; mode = 1'b0;
    @(posedge clk);
    @(negedge clk); mode = 1'b1;
    #1;
    checks++; if (route !== 1'b0) begin
      errors++; $display("FAIL auto_state_clr route got %b want 0", route); end
    @(posedge clk);
    idle_drain();
  endtask

`ifdef DEMUX_12_BEAT_CNT_EN
  task automatic test_beat_cnt();
    @(negedge clk); mode = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++; if (beats0 !== 16'd0 || beats1 !== 16'd0) begin
      errors++; $display("FAIL beats_reset got %0d %0d want 0 0", beats0, beats1); end
    @(negedge clk); rst_n = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); sel = (i < 3); din = W'(i + 7); in_valid = 1'b1;
    end
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (beats1 !== 16'd3 || beats0 !== 16'd2) begin
      errors++; $display("FAIL beats_count got b0=%0d b1=%0d want 2 3", beats0, beats1); end
  endtask
`endif

  initial begin
    test_reset();
    test_explicit();
    test_backpressure();
    test_back_to_back();
    test_auto();
`ifdef DEMUX_12_BEAT_CNT_EN
    test_beat_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
